// File: rtl/dm_responder.sv
// dm_responder: word-organised data memory responder with byte-lane stores,
// sign/zero-extended sub-word loads and load-misalignment reporting.
module dm_responder #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  Memcode,
  input  logic [31:0] Addr,
  input  logic [3:0]  BE,
  input  logic [31:0] WD,
  output logic        ack,
  output logic [31:0] RD,
  output logic        AdEL
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RDA  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [3:0] MC_SW  = 4'b0001;
  localparam logic [3:0] MC_SH  = 4'b0110;
  localparam logic [3:0] MC_SB  = 4'b0111;
  localparam logic [3:0] MC_LW  = 4'b1001;
  localparam logic [3:0] MC_LH  = 4'b1010;
  localparam logic [3:0] MC_LHU = 4'b1011;
  localparam logic [3:0] MC_LB  = 4'b1100;
  localparam logic [3:0] MC_LBU = 4'b1101;

  function automatic logic is_store_f(input logic [3:0] code);
    case (code)
      MC_SW, MC_SH, MC_SB: is_store_f = 1'b1;
      default:             is_store_f = 1'b0;
    endcase
  endfunction

  function automatic logic is_load_f(input logic [3:0] code);
    case (code)
      MC_LW, MC_LH, MC_LHU, MC_LB, MC_LBU: is_load_f = 1'b1;
      default:                             is_load_f = 1'b0;
    endcase
  endfunction

  // Byte loads can never be misaligned; halves need an even offset, words zero.
  function automatic logic misaligned_f(input logic [3:0] code, input logic [1:0] off);
    case (code)
      MC_LW:         misaligned_f = (off != 2'b00);
      MC_LH, MC_LHU: misaligned_f = off[0];
      default:       misaligned_f = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend_f(input logic [3:0]  code,
                                                input logic [31:0] word,
                                                input logic [1:0]  off);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = off[1] ? word[31:16] : word[15:0];
    byte_v = word[{off, 3'b000} +: 8];
    case (code)
      MC_LW:   load_extend_f = word;
      MC_LH:   load_extend_f = {{16{half_v[15]}}, half_v};
      MC_LHU:  load_extend_f = {16'h0000, half_v};
      MC_LB:   load_extend_f = {{24{byte_v[7]}}, byte_v};
      MC_LBU:  load_extend_f = {24'h000000, byte_v};
      default: load_extend_f = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_nx_s;
  logic [3:0]    code_r;
  logic [AW+1:0] addr_r;
  logic [3:0]    be_r;
  logic [31:0]   wd_r;
  logic          ack_r;
  logic          ack_nx_s;
  logic [31:0]   rd_r;
  logic [31:0]   rd_nx_s;
  logic          adel_r;
  logic          adel_nx_s;
  logic          capture_s;

  logic [31:0]   mem_r [0:(2**AW)-1];
  logic [AW-1:0] word_idx_s;
  logic [31:0]   rd_word_s;
  logic [31:0]   store_data_s;
  logic [3:0]    lane_we_s;
  logic          addr_unused_s;

  // Address bits above the word index wrap and are deliberately dropped.
  assign addr_unused_s = ^Addr[31:AW+2];
  assign word_idx_s    = addr_r[AW+1:2];
  assign rd_word_s     = mem_r[word_idx_s];
  assign store_data_s  = wd_r << {addr_r[1:0], 3'b000};
  assign lane_we_s     = is_store_f(code_r) ? be_r : 4'b0000;

  // Next-state and next-output decode; req is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    ack_nx_s   = 1'b0;
    rd_nx_s    = rd_r;
    adel_nx_s  = adel_r;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req) begin
          capture_s = 1'b1;
          if (is_load_f(Memcode)) begin
            if (misaligned_f(Memcode, Addr[1:0])) begin
              state_nx_s = RESP;
              ack_nx_s   = 1'b1;
              rd_nx_s    = 32'h0000_0000;
              adel_nx_s  = 1'b1;
            end else begin
              state_nx_s = RDA;
            end
          end else begin
            // Stores and unknown codes both take the WR path; unknown codes write nothing.
            state_nx_s = WR;
            ack_nx_s   = 1'b1;
            adel_nx_s  = 1'b0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WR: begin
        state_nx_s = IDLE;
      end
      RDA: begin
        state_nx_s = RESP;
        ack_nx_s   = 1'b1;
        rd_nx_s    = load_extend_f(code_r, rd_word_s, addr_r[1:0]);
        adel_nx_s  = 1'b0;
      end
      RESP: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Control state, registered outputs and captured request fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      rd_r    <= 32'h0000_0000;
      adel_r  <= 1'b0;
      code_r  <= 4'b0000;
      addr_r  <= {(AW+2){1'b0}};
      be_r    <= 4'b0000;
      wd_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_nx_s;
      ack_r   <= ack_nx_s;
      rd_r    <= rd_nx_s;
      adel_r  <= adel_nx_s;
      if (capture_s) begin
        code_r <= Memcode;
        addr_r <= Addr[AW+1:0];
        be_r   <= BE;
        wd_r   <= WD;
      end else begin
        code_r <= code_r;
        addr_r <= addr_r;
        be_r   <= be_r;
        wd_r   <= wd_r;
      end
    end
  end

  // Memory array: written on the edge leaving WR; reset clears state to IDLE so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (state_r == WR) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we_s[k]) begin
          mem_r[word_idx_s][8*k +: 8] <= store_data_s[8*k +: 8];
        end
      end
    end
  end

  assign ack  = ack_r;
  assign RD   = rd_r;
  assign AdEL = adel_r;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: transaction-level memory model plus a
// per-cycle compare process, with literal spot checks on key transactions.
module tb_dm_responder;

  localparam int AW = 10;

  localparam logic [3:0] C_NOP = 4'b0000;
  localparam logic [3:0] C_SW  = 4'b0001;
  localparam logic [3:0] C_SH  = 4'b0110;
  localparam logic [3:0] C_SB  = 4'b0111;
  localparam logic [3:0] C_LW  = 4'b1001;
  localparam logic [3:0] C_LH  = 4'b1010;
  localparam logic [3:0] C_LHU = 4'b1011;
  localparam logic [3:0] C_LB  = 4'b1100;
  localparam logic [3:0] C_LBU = 4'b1101;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  Memcode;
  logic [31:0] Addr;
  logic [3:0]  BE;
  logic [31:0] WD;
  logic        ack;
  logic [31:0] RD;
  logic        AdEL;

  dm_responder #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .Memcode(Memcode), .Addr(Addr),
    .BE(BE), .WD(WD), .ack(ack), .RD(RD), .AdEL(AdEL)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          next_free = 0;
  logic [31:0] hold_rd   = 32'h0;
  logic        hold_adel = 1'b0;

  // Expected ack events keyed by sample index, and the word-level memory model.
  bit          exp_load [int];
  logic [31:0] exp_rd   [int];
  logic        exp_adel [int];
  logic [31:0] model_mem [int];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (sample %0d): got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] code, input logic [31:0] w, input int off);
    logic [31:0] h;
    logic [31:0] b;
    h = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    case (code)
      C_LW:    return w;
      C_LH:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      C_LHU:   return h;
      C_LB:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      C_LBU:   return b;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle compare: ack only on scheduled samples, RD/AdEL hold between acks.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (!reset) begin
      chk("reset_ack", {31'b0, ack}, 32'h0);
      chk("reset_rd", RD, 32'h0);
      chk("reset_adel", {31'b0, AdEL}, 32'h0);
      hold_rd   = 32'h0;
      hold_adel = 1'b0;
      exp_load.delete();
      exp_rd.delete();
      exp_adel.delete();
    end else if (exp_load.exists(cyc)) begin
      if (exp_load[cyc]) begin
        hold_rd   = exp_rd[cyc];
        hold_adel = exp_adel[cyc];
      end else begin
        hold_adel = 1'b0;
      end
      chk("ack_expected", {31'b0, ack}, 32'h1);
      chk("ack_rd", RD, hold_rd);
      chk("ack_adel", {31'b0, AdEL}, {31'b0, hold_adel});
      exp_load.delete(cyc);
      exp_rd.delete(cyc);
      exp_adel.delete(cyc);
    end else begin
      chk("no_ack", {31'b0, ack}, 32'h0);
      chk("hold_rd", RD, hold_rd);
      chk("hold_adel", {31'b0, AdEL}, {31'b0, hold_adel});
    end
  end

  task automatic txn(input logic [3:0] code, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input bit hold,
                     output logic [31:0] rd_o, output logic adel_o, output int lat_o);
    int          c;
    int          lat;
    int          idx;
    int          off;
    int          n;
    bit          ld;
    logic        eadel;
    logic [31:0] erd;
    logic [31:0] w;
    logic [31:0] sh;
    @(negedge clk);
    req = 1'b1; Memcode = code; Addr = addr; BE = be; WD = wd;
    c = cyc + 1;
    if (c < next_free) c = next_free;
    idx = int'(addr[AW+1:2]);
    off = int'(addr[1:0]);
    ld  = (code == C_LW) || (code == C_LH) || (code == C_LHU) || (code == C_LB) || (code == C_LBU);
    erd = 32'h0; eadel = 1'b0; lat = 1;
    if (ld) begin
      if ((code == C_LW && off != 0) || ((code == C_LH || code == C_LHU) && (off % 2) == 1)) begin
        eadel = 1'b1;
      end else begin
        lat = 2;
        w   = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
        erd = model_load(code, w, off);
      end
    end else if (code == C_SW || code == C_SH || code == C_SB) begin
      w  = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      sh = wd << (8 * off);
      for (int k = 0; k < 4; k++) begin
        if (be[k]) w[8*k +: 8] = sh[8*k +: 8];
      end
      model_mem[idx] = w;
    end
    exp_load[c + lat - 1] = ld;
    exp_rd[c + lat - 1]   = erd;
    exp_adel[c + lat - 1] = eadel;
    next_free = c + lat + 1;
    while (cyc < c) begin @(posedge clk); #2; end
    n = 0;
    while (ack !== 1'b1 && n < 4) begin @(posedge clk); #2; n++; end
    lat_o  = (ack === 1'b1) ? (cyc - c + 1) : 99;
    rd_o   = RD;
    adel_o = AdEL;
    if (!hold) begin
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic        a;
    int          l;
    int          c;
    reset = 1'b0; req = 1'b0; Memcode = 4'b0000; Addr = 32'h0; BE = 4'b0000; WD = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Seed words whose untouched bytes are read later.
    txn(C_SW, 32'h14, 4'hF, 32'h11223344, 1'b0, r, a, l);
    txn(C_SW, 32'h24, 4'hF, 32'hCAFEF00D, 1'b0, r, a, l);

    txn(C_SW, 32'h10, 4'hF, 32'h80FF7F01, 1'b0, r, a, l);
    chk("sw10_latency", l, 32'd1);
    txn(C_LW, 32'h10, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lw10_latency", l, 32'd2);
    chk("lw10_rd", r, 32'h80FF7F01);
    chk("lw10_adel", {31'b0, a}, 32'h0);

    txn(C_SB, 32'h12, 4'b0100, 32'h000000AB, 1'b0, r, a, l);
    txn(C_LW, 32'h10, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("sb12_word", r, 32'h80AB7F01);
    txn(C_LB, 32'h12, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lb12_rd", r, 32'hFFFFFFAB);
    txn(C_LBU, 32'h12, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lbu12_rd", r, 32'h000000AB);

    txn(C_SH, 32'h16, 4'b1100, 32'h00009234, 1'b0, r, a, l);
    txn(C_LH, 32'h16, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lh16_rd", r, 32'hFFFF9234);
    txn(C_LHU, 32'h16, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lhu16_rd", r, 32'h00009234);
    txn(C_SW, 32'h14, 4'b0000, 32'hDEADBEEF, 1'b0, r, a, l);
    chk("sw_be0_latency", l, 32'd1);
    txn(C_LW, 32'h14, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lw14_after_be0", r, 32'h92343344);

    txn(C_LW, 32'h11, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lw11_latency", l, 32'd1);
    chk("lw11_adel", {31'b0, a}, 32'h1);
    chk("lw11_rd", r, 32'h0);
    txn(C_LH, 32'h13, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lh13_latency", l, 32'd1);
    chk("lh13_adel", {31'b0, a}, 32'h1);
    txn(C_LH, 32'h12, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lh12_rd", r, 32'hFFFF80AB);
    txn(C_LB, 32'h13, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lb13_rd", r, 32'hFFFFFF80);
    txn(C_LHU, 32'h10, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lhu10_rd", r, 32'h00007F01);

    // Unknown code behaves as an acked no-op; upper address bits wrap onto the same word.
    txn(C_NOP, 32'h10, 4'hF, 32'h00000000, 1'b0, r, a, l);
    chk("nop_latency", l, 32'd1);
    txn(C_LW, 32'h10, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("lw10_after_nop", r, 32'h80AB7F01);
    txn(C_SW, 32'h00001010, 4'hF, 32'h0BADF00D, 1'b0, r, a, l);
    txn(C_LW, 32'h10, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("wrap_rd", r, 32'h0BADF00D);

    txn(C_SW, 32'h20, 4'hF, 32'h5A5AA5A5, 1'b1, r, a, l);
    chk("b2b_sw_latency", l, 32'd1);
    txn(C_LW, 32'h20, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("b2b_lw_latency", l, 32'd2);
    chk("b2b_lw_rd", r, 32'h5A5AA5A5);

    // Reset lands while the store sits in WR, before its write edge.
    @(negedge clk);
    req = 1'b1; Memcode = C_SW; Addr = 32'h24; BE = 4'hF; WD = 32'h0BADBEEF;
    c = cyc + 1;
    if (c < next_free) c = next_free;
    exp_load[c] = 1'b0; exp_rd[c] = hold_rd; exp_adel[c] = 1'b0;
    while (cyc < c) begin @(posedge clk); #2; end
    chk("pre_reset_ack", {31'b0, ack}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_ack", {31'b0, ack}, 32'h0);
    chk("async_reset_rd", RD, 32'h0);
    chk("async_reset_adel", {31'b0, AdEL}, 32'h0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    next_free = 0;
    txn(C_LW, 32'h24, 4'h0, 32'h0, 1'b0, r, a, l);
    chk("post_reset_latency", l, 32'd2);
    chk("post_reset_lw24", r, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
